divider_32bit: RTL and testbench

Iterative 32-bit integer divider, the inverse of the team's 32-bit multiplier: same begin/end handshake style, one quotient bit per cycle. It accepts signed or unsigned operands and produces quotient and remainder after a fixed latency. It is intended to sit beside the multiplier in the execution datapath and be driven by the same control logic.

---
 rtl/divider_pkg.sv | 20 ++
 rtl/divider_if.sv | 33 +++
 rtl/div_step.sv | 34 +++
 rtl/divider_32bit.sv | 132 +++++++++++++
 tb/tb_divider_32bit.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the iterative 32-bit divider: datapath width,
// iteration counter width and the controller state encoding.
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    // One extra bit so the counter can represent the full iteration count.
    localparam int CNT_WIDTH = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        DONE,
        HOLD
    } state_e;

endpackage

// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if
// Request/result bundle between the execution control logic and the divider.
//   master : drives div_begin, div_signed, dividend, divisor;
//            observes quotient, remainder, div_busy, div_end.
//   slave  : the divider side of the same signals.
// -----------------------------------------------------------------------------
interface divider_if
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             div_begin;
    logic             div_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_busy;
    logic             div_end;

    modport master (
        output div_begin, div_signed, dividend, divisor,
        input  quotient, remainder, div_busy, div_end
    );

    modport slave (
        input  div_begin, div_signed, dividend, divisor,
        output quotient, remainder, div_busy, div_end
    );

endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One restoring-division step, purely combinational.
//   rem_in  : current partial remainder
//   dvd_bit : next dividend bit shifted into the remainder
//   dvs_mag : divisor magnitude
//   rem_out : partial remainder after the trial subtraction
//   q_bit   : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        // Extended by one more bit so the MSB of the difference is the borrow.
        diff    = {1'b0, shifted} - {2'b00, dvs_mag};
        q_bit   = ~diff[WIDTH+1];
        // Either value is below the divisor magnitude, so it fits in WIDTH bits.
        rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_32bit.sv
// -----------------------------------------------------------------------------
// divider_32bit
// Iterative signed/unsigned integer divider, one quotient bit per cycle,
// fixed 34-cycle latency from the start edge to the div_end pulse.
//   clk    : clock, rising-edge
//   resetn : asynchronous active-low reset
//   bus    : divider_if.slave (request operands in, quotient/remainder,
//            div_busy and div_end out)
// -----------------------------------------------------------------------------
module divider_32bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     resetn,
    divider_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(WIDTH - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       dvd_q, dvd_d;       // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0]       dvs_q, dvs_d;       // divisor magnitude
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic [WIDTH-1:0]       quotient_q, quotient_d;
    logic [WIDTH-1:0]       remainder_q, remainder_d;

    logic [WIDTH-1:0]       step_rem;
    logic                   step_q;
    logic                   dvd_is_neg;
    logic                   dvs_is_neg;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .dvs_mag (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    assign dvd_is_neg = bus.div_signed & bus.dividend[WIDTH-1];
    assign dvs_is_neg = bus.div_signed & bus.divisor[WIDTH-1];

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            IDLE: begin
                if (bus.div_begin) begin
                    q_neg_d = dvd_is_neg ^ dvs_is_neg;
                    r_neg_d = dvd_is_neg;
                    dvd_d   = dvd_is_neg ? -bus.dividend : bus.dividend;
                    dvs_d   = dvs_is_neg ? -bus.divisor  : bus.divisor;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Dividend bits leave at the top while quotient bits enter at the bottom.
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = q_neg_q ? -dvd_q : dvd_q;
                remainder_d = r_neg_q ? -rem_q : rem_q;
                state_d     = DONE;
            end
            DONE: begin
                state_d = bus.div_begin ? HOLD : IDLE;
            end
            HOLD: begin
                if (!bus.div_begin) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_busy  = (state_q == CALC) || (state_q == FIX);
    assign bus.div_end   = (state_q == DONE);

endmodule

// File: tb/tb_divider_32bit.sv
// -----------------------------------------------------------------------------
// tb_divider_32bit
// Self-checking bench for divider_32bit: directed corner cases, randomized
// operands against an arithmetic reference, held requests, back-to-back
// operation and asynchronous reset abort.
// -----------------------------------------------------------------------------
module tb_divider_32bit;

    logic clk;
    logic resetn;

    int n_checks;
    int n_fail;

    divider_if bus ();

    divider_32bit dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    // Reference: plain 64-bit arithmetic (truncating toward zero), with the
    // zero-divisor result defined as q = all ones, r = dividend.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = '1;
            r = a;
            return;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        lq = sa / sb;
        lr = sa % sb;
        q  = lq[31:0];
        r  = lr[31:0];
    endfunction

    // Runs one division starting at the next falling edge. div_begin stays high
    // for 'hold' cycles; operands are scrambled after the start edge. Samples
    // are taken on falling edges, k counting edges after the start edge.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int hold,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int pulses, output int busy_cycles,
                          output logic [31:0] q_mid);
        @(negedge clk);
        bus.div_begin  = 1'b1;
        bus.div_signed = sgn;
        bus.dividend   = a;
        bus.divisor    = b;
        lat         = -1;
        pulses      = 0;
        busy_cycles = 0;
        q_mid       = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (bus.div_end) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (bus.div_busy) busy_cycles++;
            if (k == 20) q_mid = bus.quotient;
            if (k >= hold) bus.div_begin = 1'b0;
            bus.div_signed = 1'($urandom_range(0, 1));
            bus.dividend   = $urandom;
            bus.divisor    = $urandom;
        end
        q = bus.quotient;
        r = bus.remainder;
    endtask

    task automatic test_reset();
        resetn         = 1'b0;
        bus.div_begin  = 1'b0;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'd0;
        bus.divisor    = 32'd0;
        #12;
        n_checks++;
        if (bus.quotient !== 32'd0) begin
            n_fail++; $display("FAIL reset_quotient: got %h want 0", bus.quotient);
        end
        n_checks++;
        if (bus.remainder !== 32'd0) begin
            n_fail++; $display("FAIL reset_remainder: got %h want 0", bus.remainder);
        end
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_end !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy %b end %b want 0 0", bus.div_busy, bus.div_end);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_end !== 1'b0) begin
            n_fail++; $display("FAIL idle_flags: busy %b end %b want 0 0", bus.div_busy, bus.div_end);
        end
    endtask

    task automatic test_directed();
        vec_t vecs[8];
        logic [31:0] q, r, q_mid;
        int lat, pulses, busy;
        vecs[0] = '{1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
        vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'h00000002, 32'h7FFFFFFF, 32'h00000001};
        vecs[4] = '{1'b1, 32'hFFFFFFFF,   32'h00000002, 32'h00000000, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, 32'h12345678,   32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        vecs[6] = '{1'b1, 32'h12345678,   32'h00000000, 32'hFFFFFFFF, 32'h12345678};
        vecs[7] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000};
        foreach (vecs[i]) begin
            do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 1, q, r, lat, pulses, busy, q_mid);
            n_checks++;
            if (q !== vecs[i].q || r !== vecs[i].r) begin
                n_fail++;
                $display("FAIL directed_%0d: q=%h r=%h want q=%h r=%h", i, q, r, vecs[i].q, vecs[i].r);
            end
            n_checks++;
            if (lat != 34 || pulses != 1 || busy != 33) begin
                n_fail++;
                $display("FAIL directed_timing_%0d: end_cycle=%0d pulses=%0d busy=%0d want 34 1 33",
                         i, lat, pulses, busy);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corner[5];
        corner = '{32'd0, 32'd1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        case ($urandom_range(0, 5))
            0:       return corner[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er, q_mid;
        logic sgn;
        int lat, pulses, busy;
        for (int n = 0; n < 150; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = pick_operand();
            b   = pick_operand();
            // A negative dividend over zero is left outside the checked set.
            if (b == 32'd0 && sgn) a[31] = 1'b0;
            model(sgn, a, b, eq, er);
            do_div(sgn, a, b, 1, q, r, lat, pulses, busy, q_mid);
            n_checks++;
            if (q !== eq || r !== er || lat != 34 || pulses != 1) begin
                n_fail++;
                $display("FAIL random_%0d: s=%b %h/%h got q=%h r=%h end=%0d pulses=%0d want q=%h r=%h end=34 pulses=1",
                         n, sgn, a, b, q, r, lat, pulses, eq, er);
            end
        end
    endtask

    task automatic test_held_begin();
        logic [31:0] q, r, eq, er, q_mid;
        int lat, pulses, busy;
        // 0x114514 / 0x1111 = 259 remainder 225 (0x103, 0xE1).
        model(1'b0, 32'h00114514, 32'h00001111, eq, er);
        do_div(1'b0, 32'h00114514, 32'h00001111, 40, q, r, lat, pulses, busy, q_mid);
        n_checks++;
        if (q !== 32'h00000103 || q !== eq || r !== er) begin
            n_fail++; $display("FAIL held_result: q=%h r=%h want q=%h r=%h", q, r, eq, er);
        end
        n_checks++;
        if (pulses != 1 || lat != 34 || busy != 33) begin
            n_fail++;
            $display("FAIL held_no_restart: pulses=%0d end_cycle=%0d busy=%0d want 1 34 33", pulses, lat, busy);
        end
        // Dropping and raising the request again must start a fresh division.
        model(1'b1, 32'hFFFFFC18, 32'd10, eq, er);
        do_div(1'b1, 32'hFFFFFC18, 32'd10, 1, q, r, lat, pulses, busy, q_mid);
        n_checks++;
        if (q !== eq || r !== er || lat != 34 || pulses != 1) begin
            n_fail++;
            $display("FAIL held_restart: q=%h r=%h end=%0d pulses=%0d want q=%h r=%h 34 1", q, r, lat, pulses, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q1, r1, q2, r2, e1, f1, e2, f2, q_mid;
        int lat, pulses, busy;
        model(1'b0, 32'd1000000, 32'd999, e1, f1);
        model(1'b1, 32'hFFFF0000, 32'h00000300, e2, f2);
        do_div(1'b0, 32'd1000000, 32'd999, 1, q1, r1, lat, pulses, busy, q_mid);
        n_checks++;
        if (q1 !== e1 || r1 !== f1) begin
            n_fail++; $display("FAIL b2b_first: q=%h r=%h want q=%h r=%h", q1, r1, e1, f1);
        end
        do_div(1'b1, 32'hFFFF0000, 32'h00000300, 1, q2, r2, lat, pulses, busy, q_mid);
        n_checks++;
        if (q_mid !== e1) begin
            n_fail++; $display("FAIL b2b_hold_previous: mid-operation q=%h want %h", q_mid, e1);
        end
        n_checks++;
        if (q2 !== e2 || r2 !== f2 || lat != 34 || pulses != 1) begin
            n_fail++;
            $display("FAIL b2b_second: q=%h r=%h end=%0d pulses=%0d want q=%h r=%h 34 1", q2, r2, lat, pulses, e2, f2);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] q, r, q_mid;
        int lat, pulses, busy, stray;
        // Leave non-zero results behind so the reset clear is observable.
        do_div(1'b0, 32'd100, 32'd7, 1, q, r, lat, pulses, busy, q_mid);
        @(negedge clk);
        bus.div_begin  = 1'b1;
        bus.div_signed = 1'b0;
        bus.dividend   = 32'hDEADBEEF;
        bus.divisor    = 32'd3;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk);
            bus.div_begin = 1'b0;
        end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            n_fail++; $display("FAIL abort_outputs: q=%h r=%h want 0 0", bus.quotient, bus.remainder);
        end
        n_checks++;
        if (bus.div_busy !== 1'b0 || bus.div_end !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags: busy %b end %b want 0 0", bus.div_busy, bus.div_end);
        end
        @(negedge clk);
        resetn = 1'b1;
        stray = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.div_end || bus.div_busy) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL abort_no_end: %0d active cycles after abort, want 0", stray);
        end
        do_div(1'b0, 32'd1000, 32'd3, 1, q, r, lat, pulses, busy, q_mid);
        n_checks++;
        if (q !== 32'd333 || r !== 32'd1 || lat != 34 || pulses != 1) begin
            n_fail++;
            $display("FAIL abort_recover: q=%h r=%h end=%0d pulses=%0d want 0000014d 00000001 34 1", q, r, lat, pulses);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_held_begin();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
